snake_renderer: RTL and testbench

SNAKE_RENDERER -- requirements
Module: snake_renderer

---
 rtl/snake_renderer_pkg.sv | 23 ++
 rtl/snake_renderer_rect_hit.sv | 34 +++
 rtl/snake_renderer.sv | 126 ++++++++++++
 tb/tb_snake_renderer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_renderer_pkg.sv
// Shared types and geometry constants for the snake renderer slice.
package snakePkg;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } pt2D;

    localparam int N_800 = 800;
    localparam int N_600 = 600;

    localparam int SNAKE_MAX_DEF = 32;
    localparam int SEG_W_DEF     = 18;
    localparam int SEG_H_DEF     = 18;
    localparam int APPLE_W_DEF   = 10;
    localparam int APPLE_H_DEF   = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/snake_renderer_rect_hit.sv
// Combinational inclusive-bounds rectangle test for one object origin.
module rect_hit
    import snakePkg::*;
#(
    parameter int W = SEG_W_DEF,
    parameter int H = SEG_H_DEF
) (
    input  logic [10:0] ppc,
    input  logic [9:0]  plc,
    input  pt2D         origin,
    output logic        hit
);

    localparam logic [11:0] W_LAST = 12'(W - 1);
    localparam logic [10:0] H_LAST = 11'(H - 1);

    logic [11:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        on_screen;

    // End coordinates are one bit wider so a rectangle near the top of the
    // coordinate range never wraps; parts past the visible area are clipped.
    always_comb begin
        x_end     = {1'b0, origin.x} + W_LAST;
        y_end     = {1'b0, origin.y} + H_LAST;
        in_x      = (ppc >= origin.x) && ({1'b0, ppc} <= x_end);
        in_y      = (plc >= origin.y) && ({1'b0, plc} <= y_end);
        on_screen = (ppc < 11'(N_800)) && (plc < 10'(N_600));
        hit       = in_x && in_y && on_screen;
    end

endmodule

// File: rtl/snake_renderer.sv
// Per-pixel snake/apple renderer with frame-shadowed positions and per-frame collision flags.
module snake_renderer
    import snakePkg::*;
#(
    parameter int SNAKE_MAX = SNAKE_MAX_DEF,
    parameter int SEG_W     = SEG_W_DEF,
    parameter int SEG_H     = SEG_H_DEF,
    parameter int APPLE_W   = APPLE_W_DEF,
    parameter int APPLE_H   = APPLE_H_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10:0]                    ppc,
    input  logic [9:0]                     plc,
    input  logic                           pix_valid,
    input  logic                           frame_start,
    input  pt2D [SNAKE_MAX-1:0]            snake_pos,
    input  logic [$clog2(SNAKE_MAX+1)-1:0] snake_len,
    input  pt2D                            apple_pos,
    output logic [1:0]                     status,
    output logic                           head_px,
    output logic                           pix_valid_o,
    output logic                           self_col,
    output logic                           apple_eaten,
    output logic                           frame_done
);

    localparam int LEN_W = $clog2(SNAKE_MAX + 1);

    state_t                 state;
    pt2D [SNAKE_MAX-1:0]    sh_pos;
    pt2D                    sh_apple;
    logic [LEN_W-1:0]       sh_len;

    logic [SNAKE_MAX-1:0]   seg_hit;
    logic [SNAKE_MAX-1:0]   live;
    logic                   apple_hit;
    logic                   pix_ok;

    logic [SNAKE_MAX-1:0]   s1_seg;
    logic                   s1_apple;
    logic                   s1_valid;
    logic                   self_hit;
    logic                   eat_hit;

    logic                   pub_pending;
    logic                   self_acc;
    logic                   apple_acc;

    for (genvar i = 0; i < SNAKE_MAX; i++) begin : g_seg
        rect_hit #(.W(SEG_W), .H(SEG_H)) u_seg_hit (
            .ppc    (ppc),
            .plc    (plc),
            .origin (sh_pos[i]),
            .hit    (seg_hit[i])
        );
        assign live[i] = (i < int'(sh_len));
    end

    rect_hit #(.W(APPLE_W), .H(APPLE_H)) u_apple_hit (
        .ppc    (ppc),
        .plc    (plc),
        .origin (sh_apple),
        .hit    (apple_hit)
    );

    // The frame_start cycle itself carries no pixel, and nothing renders before the first frame.
    assign pix_ok   = pix_valid && !frame_start && (state == ACTIVE);
    assign self_hit = s1_seg[0] && (|(s1_seg & ~SNAKE_MAX'(1)));
    assign eat_hit  = s1_seg[0] && s1_apple;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sh_pos   <= '0;
            sh_apple <= '0;
            sh_len   <= '0;
        end else if (frame_start) begin
            state    <= ACTIVE;
            sh_pos   <= snake_pos;
            sh_apple <= apple_pos;
            sh_len   <= (snake_len > LEN_W'(SNAKE_MAX)) ? LEN_W'(SNAKE_MAX) : snake_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_seg      <= '0;
            s1_apple    <= 1'b0;
            s1_valid    <= 1'b0;
            status      <= 2'b00;
            head_px     <= 1'b0;
            pix_valid_o <= 1'b0;
        end else begin
            s1_seg      <= pix_ok ? (seg_hit & live) : '0;
            s1_apple    <= pix_ok && apple_hit;
            s1_valid    <= pix_ok;
            status      <= {s1_apple, |s1_seg};
            head_px     <= s1_seg[0];
            pix_valid_o <= s1_valid;
        end
    end

    // Publishing one cycle after frame_start lets the last pre-frame pixel reach
    // the accumulators first; the clear lands on the same edge as the publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pub_pending <= 1'b0;
            self_acc    <= 1'b0;
            apple_acc   <= 1'b0;
            self_col    <= 1'b0;
            apple_eaten <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pub_pending <= frame_start && (state == ACTIVE);
            frame_done  <= pub_pending;
            self_acc    <= (self_acc  && !pub_pending) || self_hit;
            apple_acc   <= (apple_acc && !pub_pending) || eat_hit;
            if (pub_pending) begin
                self_col    <= self_acc;
                apple_eaten <= apple_acc;
            end
        end
    end

endmodule

// File: tb/tb_snake_renderer.sv
// Directed self-checking bench for snake_renderer: pixel hits, frame collisions, reset.
module tb_snake_renderer;
    import snakePkg::*;

    logic              clk;
    logic              rst;
    logic [10:0]       ppc;
    logic [9:0]        plc;
    logic              pix_valid;
    logic              frame_start;
    pt2D [31:0]        snake_pos;
    logic [5:0]        snake_len;
    pt2D               apple_pos;
    logic [1:0]        status;
    logic              head_px;
    logic              pix_valid_o;
    logic              self_col;
    logic              apple_eaten;
    logic              frame_done;

    int checks = 0;
    int passes = 0;

    snake_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .ppc         (ppc),
        .plc         (plc),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .snake_pos   (snake_pos),
        .snake_len   (snake_len),
        .apple_pos   (apple_pos),
        .status      (status),
        .head_px     (head_px),
        .pix_valid_o (pix_valid_o),
        .self_col    (self_col),
        .apple_eaten (apple_eaten),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pt2D pt(input int x, input int y);
        pt2D p;
        p.x = 11'(x);
        p.y = 10'(y);
        return p;
    endfunction

    // One pixel; returns at the negedge where its status/head_px/pix_valid_o are visible.
    task automatic apply_pixel(input int x, input int y, input logic v);
        @(negedge clk);
        ppc = 11'(x);
        plc = 10'(y);
        pix_valid = v;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge where the publication (frame_done) is visible.
    task automatic pulse_frame_start();
        @(negedge clk);
        pix_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_region(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                @(negedge clk);
                ppc = 11'(x);
                plc = 10'(y);
                pix_valid = 1'b1;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        repeat (2) @(negedge clk);
        outs = {status, head_px, pix_valid_o, self_col, apple_eaten, frame_done};
        checks++;
        if (outs !== 7'b0) $display("[TB] FAIL reset_outputs: got %b expected 0000000", outs);
        else passes++;
        rst = 1'b1;
        snake_pos[0] = pt(100, 100);
        snake_len = 6'd1;
        apply_pixel(105, 105, 1'b1);
        outs = {status, head_px, pix_valid_o, self_col, apple_eaten, frame_done};
        checks++;
        if (outs !== 7'b0) $display("[TB] FAIL idle_ignores_pixels: got %b expected 0000000", outs);
        else passes++;
    endtask

    task automatic test_head_pixel();
        snake_pos[0] = pt(100, 100);
        snake_len = 6'd1;
        apple_pos = pt(700, 500);
        pulse_frame_start();
        checks++;
        if (frame_done !== 1'b0) $display("[TB] FAIL first_frame_no_publish: frame_done=%b expected 0", frame_done);
        else passes++;
        apply_pixel(117, 117, 1'b1);
        checks++;
        if ({status, head_px, pix_valid_o} !== 4'b0111)
            $display("[TB] FAIL head_corner_hit: got %b expected 0111", {status, head_px, pix_valid_o});
        else passes++;
        apply_pixel(118, 100, 1'b1);
        checks++;
        if ({status, head_px, pix_valid_o} !== 4'b0001)
            $display("[TB] FAIL head_right_miss: got %b expected 0001", {status, head_px, pix_valid_o});
        else passes++;
        apply_pixel(100, 100, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b011) $display("[TB] FAIL head_origin_hit: got %b expected 011", {status, head_px});
        else passes++;
    endtask

    task automatic test_apple_pixel();
        apple_pos = pt(200, 50);
        pulse_frame_start();
        apply_pixel(209, 59, 1'b1);
        checks++;
        if ({status, head_px, pix_valid_o} !== 4'b1001)
            $display("[TB] FAIL apple_corner_hit: got %b expected 1001", {status, head_px, pix_valid_o});
        else passes++;
        apply_pixel(210, 59, 1'b1);
        checks++;
        if (status !== 2'b00) $display("[TB] FAIL apple_right_miss: status=%b expected 00", status);
        else passes++;
        apply_pixel(205, 55, 1'b0);
        checks++;
        if ({status, pix_valid_o} !== 3'b000)
            $display("[TB] FAIL apple_invalid_pixel: got %b expected 000", {status, pix_valid_o});
        else passes++;
    endtask

    task automatic test_self_collision();
        snake_pos[0] = pt(300, 300);
        snake_pos[1] = pt(310, 300);
        snake_len = 6'd2;
        apple_pos = pt(700, 500);
        pulse_frame_start();
        scan_region(300, 330, 300, 317);
        pulse_frame_start();
        checks++;
        if ({frame_done, self_col, apple_eaten} !== 3'b110)
            $display("[TB] FAIL self_col_len2: {frame_done,self_col,apple_eaten}=%b expected 110", {frame_done, self_col, apple_eaten});
        else passes++;
        @(negedge clk);
        checks++;
        if ({frame_done, self_col} !== 2'b01)
            $display("[TB] FAIL self_col_held: {frame_done,self_col}=%b expected 01", {frame_done, self_col});
        else passes++;
        snake_len = 6'd1;
        pulse_frame_start();
        scan_region(300, 330, 300, 317);
        pulse_frame_start();
        checks++;
        if ({frame_done, self_col} !== 2'b10)
            $display("[TB] FAIL self_col_len1: {frame_done,self_col}=%b expected 10", {frame_done, self_col});
        else passes++;
    endtask

    task automatic test_apple_eaten_and_shadow();
        snake_pos[0] = pt(40, 40);
        apple_pos = pt(50, 50);
        snake_len = 6'd1;
        pulse_frame_start();
        scan_region(40, 59, 40, 59);
        pulse_frame_start();
        checks++;
        if ({frame_done, self_col, apple_eaten} !== 3'b101)
            $display("[TB] FAIL apple_eaten: {frame_done,self_col,apple_eaten}=%b expected 101", {frame_done, self_col, apple_eaten});
        else passes++;
        snake_pos[0] = pt(400, 400);
        apply_pixel(45, 45, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b011) $display("[TB] FAIL shadow_old_head: got %b expected 011", {status, head_px});
        else passes++;
        apply_pixel(405, 405, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b000) $display("[TB] FAIL shadow_new_head: got %b expected 000", {status, head_px});
        else passes++;
    endtask

    task automatic test_edges();
        snake_pos[0] = pt(795, 100);
        apple_pos = pt(0, 0);
        snake_len = 6'd1;
        pulse_frame_start();
        apply_pixel(799, 105, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b011) $display("[TB] FAIL right_edge_hit: got %b expected 011", {status, head_px});
        else passes++;
        apply_pixel(812, 105, 1'b1);
        checks++;
        if (status !== 2'b00) $display("[TB] FAIL offscreen_clip: status=%b expected 00", status);
        else passes++;
        snake_pos[0] = pt(2040, 100);
        pulse_frame_start();
        apply_pixel(5, 105, 1'b1);
        checks++;
        if (status !== 2'b00) $display("[TB] FAIL no_wrap: status=%b expected 00", status);
        else passes++;
        snake_pos[0] = pt(100, 100);
        snake_pos[31] = pt(600, 300);
        snake_len = 6'd40;
        pulse_frame_start();
        apply_pixel(605, 305, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b010) $display("[TB] FAIL len_clamp_last_seg: got %b expected 010", {status, head_px});
        else passes++;
        snake_len = 6'd31;
        pulse_frame_start();
        apply_pixel(605, 305, 1'b1);
        checks++;
        if (status !== 2'b00) $display("[TB] FAIL len31_seg31_dead: status=%b expected 00", status);
        else passes++;
        snake_len = 6'd0;
        pulse_frame_start();
        apply_pixel(105, 105, 1'b1);
        checks++;
        if ({status, head_px} !== 3'b000) $display("[TB] FAIL len0_nothing: got %b expected 000", {status, head_px});
        else passes++;
        snake_pos[31] = pt(700, 550);
    endtask

    task automatic test_back_to_back();
        snake_pos[0] = pt(40, 40);
        apple_pos = pt(50, 50);
        snake_len = 6'd1;
        pulse_frame_start();
        // Pixel in the cycle just before frame_start must still count for the old frame.
        @(negedge clk);
        ppc = 11'd52;
        plc = 10'd52;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        ppc = 11'd45;
        plc = 10'd45;
        pix_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid = 1'b0;
        checks++;
        if ({frame_done, apple_eaten} !== 2'b11)
            $display("[TB] FAIL b2b_first_publish: {frame_done,apple_eaten}=%b expected 11", {frame_done, apple_eaten});
        else passes++;
        @(negedge clk);
        checks++;
        if ({frame_done, apple_eaten, status, pix_valid_o} !== 5'b10000)
            $display("[TB] FAIL b2b_second_fresh: {frame_done,apple_eaten,status,pix_valid_o}=%b expected 10000", {frame_done, apple_eaten, status, pix_valid_o});
        else passes++;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) $display("[TB] FAIL b2b_done_ends: frame_done=%b expected 0", frame_done);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] outs;
        snake_pos[0] = pt(40, 40);
        apple_pos = pt(50, 50);
        snake_len = 6'd1;
        pulse_frame_start();
        apply_pixel(52, 52, 1'b1);
        pulse_frame_start();
        @(negedge clk);
        ppc = 11'd45;
        plc = 10'd45;
        pix_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if ({status, head_px, apple_eaten} !== 4'b0111)
            $display("[TB] FAIL pre_reset_inflight: {status,head_px,apple_eaten}=%b expected 0111", {status, head_px, apple_eaten});
        else passes++;
        #1 rst = 1'b0;
        #1;
        outs = {status, head_px, pix_valid_o, self_col, apple_eaten, frame_done};
        checks++;
        if (outs !== 7'b0) $display("[TB] FAIL async_reset_clear: got %b expected 0000000", outs);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply_pixel(45, 45, 1'b1);
        checks++;
        if ({status, head_px, pix_valid_o} !== 4'b0000)
            $display("[TB] FAIL post_reset_idle: got %b expected 0000", {status, head_px, pix_valid_o});
        else passes++;
        pulse_frame_start();
        checks++;
        if (frame_done !== 1'b0) $display("[TB] FAIL post_reset_no_publish: frame_done=%b expected 0", frame_done);
        else passes++;
        apply_pixel(45, 45, 1'b1);
        checks++;
        if ({status, head_px, pix_valid_o} !== 4'b0111)
            $display("[TB] FAIL post_reset_render: got %b expected 0111", {status, head_px, pix_valid_o});
        else passes++;
    endtask

    initial begin
        rst = 1'b0;
        ppc = '0;
        plc = '0;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        snake_len = '0;
        apple_pos = pt(700, 500);
        for (int i = 0; i < 32; i++) snake_pos[i] = pt(700, 550);

        test_reset();
        test_head_pixel();
        test_apple_pixel();
        test_self_collision();
        test_apple_eaten_and_shadow();
        test_edges();
        test_back_to_back();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
